// File: rtl/inst_fetch_if.sv
// inst_fetch_if: instruction-memory bus between the fetch stage (master)
// and the instruction memory (slave). Request/grant with one response
// per grant, earliest the cycle after the grant.
interface inst_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: RV32 instruction-fetch stage.
// Keeps the PC, issues one word fetch at a time over inst_fetch_if, and
// presents inst/inst_pc/inst_valid to decode. A one-entry buffer absorbs a
// response that lands while decode holds. A redirect from execute squashes
// whatever is in flight (S_DROP swallows an already-granted response).
// Optional feature: define IF_MISALIGN_CHK_EN to flag redirects to
// non-word-aligned targets on the sticky 'error' output.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold,
  input  logic         jump_en,
  input  logic [31:0]  jump_addr,
  inst_fetch_if.master imem,
  output logic [31:0]  inst,
  output logic [31:0]  inst_pc,
  output logic         inst_valid,
  output logic         error
);

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // requesting imem_addr = pc
    S_WAIT = 2'd1,  // granted, waiting for the response
    S_FULL = 2'd2,  // response parked in buf_q while decode holds
    S_DROP = 2'd3   // granted response belongs to a squashed path
  } state_t;

  state_t      state;
  logic [31:0] pc;        // next address to fetch
  logic [31:0] fetch_pc;  // address of the fetch in flight / buffered
  logic [31:0] buf_q;     // response captured under hold
  logic [31:0] jump_tgt;

  // Redirect targets are forced word aligned.
  assign jump_tgt = {jump_addr[31:2], 2'b00};

  // Request side depends only on registered state, never on inputs.
  assign imem.imem_req  = (state == S_REQ);
  assign imem.imem_addr = pc;

  // Fetch FSM, PC and decode-facing output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_REQ;
      pc         <= PC_INIT;
      fetch_pc   <= '0;
      buf_q      <= '0;
      inst       <= NOP;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
    end else if (jump_en) begin
      // Redirect wins over hold and over any load; the buffer is simply
      // abandoned by leaving S_FULL.
      pc         <= jump_tgt;
      inst_valid <= 1'b0;
      case (state)
        // A grant this cycle means a response is still coming: drop it.
        S_REQ:   state <= imem.imem_gnt    ? S_DROP : S_REQ;
        // Response arriving now is discarded; otherwise wait it out.
        S_WAIT:  state <= imem.imem_rvalid ? S_REQ  : S_DROP;
        S_FULL:  state <= S_REQ;
        S_DROP:  state <= imem.imem_rvalid ? S_REQ  : S_DROP;
        default: state <= S_REQ;
      endcase
    end else begin
      // Default: a non-held cycle without a load is a bubble.
      if (!hold) inst_valid <= 1'b0;
      case (state)
        S_REQ: begin
          if (imem.imem_gnt) begin
            fetch_pc <= pc;
            pc       <= pc + 32'd4;  // wraps modulo 2^32
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            if (hold) begin
              buf_q <= imem.imem_rdata;
              state <= S_FULL;
            end else begin
              inst       <= imem.imem_rdata;
              inst_pc    <= fetch_pc;
              inst_valid <= 1'b1;
              state      <= S_REQ;
            end
          end
        end
        S_FULL: begin
          if (!hold) begin
            inst       <= buf_q;
            inst_pc    <= fetch_pc;
            inst_valid <= 1'b1;
            state      <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem.imem_rvalid) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

`ifdef IF_MISALIGN_CHK_EN
  // Sticky fault: any redirect whose target is not word aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      error <= 1'b0;
    else if (jump_en && (jump_addr[1:0] != 2'b00))   error <= 1'b1;
  end
`else
  // Low target bits are ignored entirely in this build.
  logic unused_jump_lsb;
  assign unused_jump_lsb = ^jump_addr[1:0];
  assign error = 1'b0;
`endif

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage of the RV32 core, directly upstream of instruction decode. Holds the program counter and issues word fetches to the instruction memory over a request/grant/response handshake. Presents each fetched instruction with its PC and a valid flag to decode. Honours pipeline `hold` through a one-entry buffer and squashes in-flight fetches on a jump/branch redirect from execute.

## Interface
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset; bits [1:0] must be 0.
- `clk`  in  1  core clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `hold`  in  1  decode stall: output registers must not change.
- `jump_en`  in  1  redirect request from execute, single-cycle pulse.
- `jump_addr`  in  32  redirect target.
- `imem_req`  out  1  fetch request, level, held until granted.
- `imem_addr`  out  32  fetch address, stable while `imem_req`=1.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  read data valid, exactly one per grant, earliest the cycle after grant.
- `imem_rdata`  in  32  instruction word.
- `inst`  out  32  instruction to decode.
- `inst_pc`  out  32  address of `inst`.
- `inst_valid`  out  1  `inst` is a real instruction; 0 is a bubble.
- `error`  out  1  sticky fault flag (see Configuration).

## Operation
- Registers: `pc` (next fetch address), `fetch_pc` (address in flight), 32-bit buffer, state.
- States: S_REQ, S_WAIT, S_FULL, S_DROP. At most one outstanding fetch.
- S_REQ: `imem_req`=1, `imem_addr`=`pc`. On `imem_gnt`: `fetch_pc`<=`pc`, `pc`<=`pc`+4, go S_WAIT.
- S_WAIT: `imem_req`=0. On `imem_rvalid` with `hold`=0: `inst`<=`imem_rdata`, `inst_pc`<=`fetch_pc`, `inst_valid`<=1, go S_REQ. With `hold`=1: buffer<=`imem_rdata`, go S_FULL.
- S_FULL: `imem_req`=0; when `hold`=0 load outputs from buffer/`fetch_pc`, `inst_valid`<=1, go S_REQ.
- S_DROP: `imem_req`=0; next `imem_rvalid` is discarded, go S_REQ.
- Bubble: in any state, cycle with `hold`=0 and no load -> `inst_valid`<=0; `inst`/`inst_pc` keep their values.
- `hold`=1 and no redirect: `inst`, `inst_pc`, `inst_valid` unchanged.
- Redirect (`jump_en`=1) has priority over `hold` and over every load:
  - `pc`<={`jump_addr`[31:2],2'b00}; `inst_valid`<=0; buffer contents discarded.
  - From S_REQ with no grant, S_FULL, or S_WAIT with `imem_rvalid` this cycle: go S_REQ.
  - From S_REQ with `imem_gnt` the same cycle, or S_WAIT without `imem_rvalid`: go S_DROP. The old fetch is granted but never presented.
  - From S_DROP: stay S_DROP, unless `imem_rvalid` this cycle -> S_REQ.
- `pc` increments modulo 2^32; 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset (async assert, sync release): state S_REQ, `pc`=`RESET_PC`, `inst`=32'h0000_0013 (NOP), `inst_pc`=0, `inst_valid`=0, `error`=0, buffer=0. `imem_req`=1 the first cycle after release.
- `imem_req`/`imem_addr` are decoded from registered state and `pc` only; no combinational path from any input.
- Zero-wait memory (grant in cycle T, rvalid T+1): `inst_valid`=1 at T+2. Sustained rate is 1 instruction per 2 cycles.
- Redirect at cycle T: `imem_addr`=target no earlier than T+1. First valid target instruction appears at T+3 with zero-wait memory and no pending fetch.
- Reset mid-fetch: the outstanding response is not tracked; memory must also be reset by `rst_n`.

## Configuration
- `IF_MISALIGN_CHK_EN` defined: a redirect with `jump_addr`[1:0]!=0 sets `error`<=1, sticky until reset. The redirect is still performed with bits [1:0] cleared.
- Not defined: `jump_addr`[1:0] silently cleared; `error` tied to 0.

## Test plan
- Reset release, zero-wait memory returning addr-based words: `inst_pc` = 0,4,8,... with `inst_valid` pulsing every other cycle; first valid 2 cycles after first grant.
- `hold`=1 across an rvalid carrying 32'h00500093: outputs frozen, `imem_req`=0. `hold`=0 -> next edge `inst`=32'h00500093, `inst_valid`=1, then `imem_req`=1.
- `jump_en` with `jump_addr`=32'h100 while in S_WAIT: the following rvalid is dropped, next `imem_addr`=32'h100, next valid `inst_pc`=32'h100.
- `jump_en` in the same cycle as `imem_gnt` for 32'h8: the response for 32'h8 never appears, and a fetch of the target follows.
- `jump_addr`=32'h102: `imem_addr`=32'h100. `error`=1 and sticky with `IF_MISALIGN_CHK_EN`, 0 without.
- `RESET_PC`=32'hFFFF_FFFC: second fetch address is 32'h0.
